// File: rtl/req_agg.sv
// Purpose: per-source pending-request aggregator in front of the 4-way arbiter controller.
// Latency: 1 cycle from src_req to src_ack and to req_i; a grant retires a request on the same edge.
// Backpressure: none upstream; a request to a full channel is dropped, unacked, and flagged in ovf.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   src_req/src_ack request pulse per source, registered accept pulse one cycle later
//   req_0..req_3    level request to ctrl, high while that channel's count is nonzero
//   gnt             grant pulse from ctrl, retires one pending request of that channel
//   clr_err         clears the sticky flags ovf, tmo, spur and gnt_err
//   pend_cnt        pending counts, channel i at [i*CNT_W +: CNT_W]
module req_agg #(
    parameter int CNT_W   = 3,
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 200
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           src_req,
    output logic [3:0]           src_ack,
    output logic                 req_0,
    output logic                 req_1,
    output logic                 req_2,
    output logic                 req_3,
    input  logic [3:0]           gnt,
    input  logic                 clr_err,
    output logic [4*CNT_W-1:0]   pend_cnt,
    output logic [3:0]           ovf,
    output logic [3:0]           tmo,
    output logic [3:0]           spur,
    output logic                 gnt_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TMO_W-1:0] AGE_MAX = TMO_W'(TMO_MAX);

    logic [3:0] busy;
    logic [3:0] inc;
    logic [3:0] ovf_set;
    logic [3:0] tmo_set;
    logic [3:0] spur_set;
    logic       gnt_err_set;

    for (genvar i = 0; i < 4; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q;
        logic [TMO_W-1:0] age_q;
        logic             full;
        logic             dec;

        assign full   = (cnt_q == CNT_MAX);
        // A grant on a full channel frees a slot in the same edge, so the
        // simultaneous request is accepted instead of dropped.
        assign inc[i] = src_req[i] & (~full | gnt[i]);
        assign dec    = gnt[i] & (cnt_q != '0);
        assign busy[i] = (cnt_q != '0);
        assign pend_cnt[i*CNT_W +: CNT_W] = cnt_q;

        assign ovf_set[i]  = src_req[i] & full & ~gnt[i];
        assign spur_set[i] = gnt[i] & ~busy[i];
        // Flag on the edge where the age counter lands on TMO_MAX.
        assign tmo_set[i]  = busy[i] & ~gnt[i] & (age_q == AGE_MAX - TMO_W'(1));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q <= '0;
            end else if (inc[i] & ~dec) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (dec & ~inc[i]) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end

        // Age measures how long the current request level has waited for a
        // grant; any grant restarts it.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                age_q <= '0;
            end else if (~busy[i] | gnt[i]) begin
                age_q <= '0;
            end else if (age_q != AGE_MAX) begin
                age_q <= age_q + TMO_W'(1);
            end
        end
    end

    // Two or more grant bits at once: clearing the lowest set bit leaves a nonzero value.
    assign gnt_err_set = ((gnt & (gnt - 4'd1)) != 4'd0);

    assign req_0 = busy[0];
    assign req_1 = busy[1];
    assign req_2 = busy[2];
    assign req_3 = busy[3];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_ack <= '0;
        end else begin
            src_ack <= inc;
        end
    end

    // Sticky flags: a set in the same cycle as clr_err takes priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf     <= '0;
            tmo     <= '0;
            spur    <= '0;
            gnt_err <= 1'b0;
        end else begin
            ovf     <= (ovf  & {4{~clr_err}}) | ovf_set;
            tmo     <= (tmo  & {4{~clr_err}}) | tmo_set;
            spur    <= (spur & {4{~clr_err}}) | spur_set;
            gnt_err <= (gnt_err & ~clr_err) | gnt_err_set;
        end
    end

endmodule

// File: tb/tb_req_agg.sv
module tb_req_agg;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src_req;
    logic [3:0]  src_ack;
    logic        req_0, req_1, req_2, req_3;
    logic [3:0]  gnt;
    logic        clr_err;
    logic [11:0] pend_cnt;
    logic [3:0]  ovf, tmo, spur;
    logic        gnt_err;

    req_agg #(.CNT_W(3), .TMO_W(8), .TMO_MAX(200)) dut (
        .clk      (clk),
        .reset    (reset),
        .src_req  (src_req),
        .src_ack  (src_ack),
        .req_0    (req_0),
        .req_1    (req_1),
        .req_2    (req_2),
        .req_3    (req_3),
        .gnt      (gnt),
        .clr_err  (clr_err),
        .pend_cnt (pend_cnt),
        .ovf      (ovf),
        .tmo      (tmo),
        .spur     (spur),
        .gnt_err  (gnt_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int due; logic [3:0] mask; } ack_t;
    typedef struct { int due; int kind; logic [31:0] exp; } chk_t;

    ack_t ack_q[$];
    chk_t chk_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam int K_PEND = 0, K_REQ = 1, K_OVF = 2, K_TMO = 3, K_SPUR = 4, K_GERR = 5, K_ACK = 6;

    function automatic string kname(int k);
        case (k)
            K_PEND:  return "pend_cnt";
            K_REQ:   return "req_3..0";
            K_OVF:   return "ovf";
            K_TMO:   return "tmo";
            K_SPUR:  return "spur";
            K_GERR:  return "gnt_err";
            default: return "src_ack";
        endcase
    endfunction

    function automatic logic [31:0] actual(int k);
        case (k)
            K_PEND:  return {20'b0, pend_cnt};
            K_REQ:   return {28'b0, req_3, req_2, req_1, req_0};
            K_OVF:   return {28'b0, ovf};
            K_TMO:   return {28'b0, tmo};
            K_SPUR:  return {28'b0, spur};
            K_GERR:  return {31'b0, gnt_err};
            default: return {28'b0, src_ack};
        endcase
    endfunction

    // Pack four channel counts into the pend_cnt layout.
    function automatic logic [31:0] pc(int a, int b, int c, int d);
        return {20'b0, d[2:0], c[2:0], b[2:0], a[2:0]};
    endfunction

    task automatic compare(string name, int due, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, due, act, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        ack_t a;
        chk_t c;
        while (ack_q.size() > 0 && ack_q[0].due < cyc) begin
            a = ack_q.pop_front();
            compare("ack_stale", a.due, 32'(cyc), 32'(a.due));
        end
        if (ack_q.size() > 0 && ack_q[0].due == cyc) begin
            a = ack_q.pop_front();
            compare("src_ack", cyc, {28'b0, src_ack}, {28'b0, a.mask});
        end else if (src_ack != 4'b0) begin
            compare("src_ack_unexpected", cyc, {28'b0, src_ack}, 32'b0);
        end
        while (chk_q.size() > 0 && chk_q[0].due <= cyc) begin
            c = chk_q.pop_front();
            if (c.due < cyc) compare("chk_stale", c.due, 32'(cyc), 32'(c.due));
            else             compare(kname(c.kind), cyc, actual(c.kind), c.exp);
        end
    end

    // Expectation for the registered outputs visible during the current cycle.
    task automatic ex(int kind, logic [31:0 ] val);
        chk_q.push_back('{cyc, kind, val});
    endtask

    // Apply inputs for one active edge; exp_ack is the ack expected after that edge.
    task automatic step(logic [3:0] r, logic [3:0] g, logic c, logic [3:0] exp_ack);
        src_req = r;
        gnt     = g;
        clr_err = c;
        if (r != 4'b0) ack_q.push_back('{cyc + 1, exp_ack});
        @(posedge clk);
        #1;
        src_req = 4'b0;
        gnt     = 4'b0;
        clr_err = 1'b0;
    endtask

    task automatic ex_flags(logic [3:0] o, logic [3:0] t, logic [3:0] s, logic ge);
        ex(K_OVF, {28'b0, o});
        ex(K_TMO, {28'b0, t});
        ex(K_SPUR, {28'b0, s});
        ex(K_GERR, {31'b0, ge});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        src_req = 4'b0;
        gnt     = 4'b0;
        clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        ex(K_PEND, 32'b0);
        ex(K_REQ, 32'b0);
        ex(K_ACK, 32'b0);
        ex_flags(4'b0, 4'b0, 4'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single request then grant on channel 0
        step(4'b0001, 4'b0000, 1'b0, 4'b0001);
        ex(K_PEND, pc(1, 0, 0, 0));
        ex(K_REQ, 32'b0001);
        step(4'b0000, 4'b0001, 1'b0, 4'b0000);
        ex(K_PEND, 32'b0);
        ex(K_REQ, 32'b0);
        ex_flags(4'b0, 4'b0, 4'b0, 1'b0);

        // Fill channel 2: seven accepted, eighth dropped
        for (int i = 0; i < 7; i++) step(4'b0100, 4'b0000, 1'b0, 4'b0100);
        ex(K_PEND, pc(0, 0, 7, 0));
        ex(K_OVF, 32'b0);
        step(4'b0100, 4'b0000, 1'b0, 4'b0000);
        ex(K_PEND, pc(0, 0, 7, 0));
        ex(K_REQ, 32'b0100);
        ex(K_OVF, 32'b0100);
        // Full with request and grant together: accepted, count unchanged
        step(4'b0100, 4'b0100, 1'b0, 4'b0100);
        ex(K_PEND, pc(0, 0, 7, 0));
        ex(K_OVF, 32'b0100);
        ex(K_SPUR, 32'b0);

        // Spurious grant on idle channel 3, set beats clear, then clear
        step(4'b0000, 4'b1000, 1'b0, 4'b0000);
        ex(K_SPUR, 32'b1000);
        ex(K_PEND, pc(0, 0, 7, 0));
        step(4'b0000, 4'b1000, 1'b1, 4'b0000);
        ex(K_SPUR, 32'b1000);
        ex(K_OVF, 32'b0);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000);
        ex(K_SPUR, 32'b0);

        // Drain channel 2
        for (int i = 0; i < 7; i++) step(4'b0000, 4'b0100, 1'b0, 4'b0000);
        ex(K_PEND, 32'b0);
        ex(K_REQ, 32'b0);
        ex_flags(4'b0, 4'b0, 4'b0, 1'b0);

        // Timeout on channel 1: tmo rises exactly 200 edges after req_1 rises
        step(4'b0010, 4'b0000, 1'b0, 4'b0010);
        ex(K_REQ, 32'b0010);
        for (int i = 0; i < 199; i++) step(4'b0000, 4'b0000, 1'b0, 4'b0000);
        ex(K_TMO, 32'b0);
        step(4'b0000, 4'b0000, 1'b0, 4'b0000);
        ex(K_TMO, 32'b0010);
        step(4'b0000, 4'b0010, 1'b0, 4'b0000);
        ex(K_PEND, 32'b0);
        ex(K_TMO, 32'b0010);
        step(4'b0000, 4'b0000, 1'b0, 4'b0000);
        ex(K_TMO, 32'b0010);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000);
        ex(K_TMO, 32'b0);

        // Multi-hot grant on channels 0 and 3
        step(4'b1001, 4'b0000, 1'b0, 4'b1001);
        step(4'b1001, 4'b0000, 1'b0, 4'b1001);
        step(4'b1000, 4'b0000, 1'b0, 4'b1000);
        ex(K_PEND, pc(2, 0, 0, 3));
        step(4'b0000, 4'b1001, 1'b0, 4'b0000);
        ex(K_PEND, pc(1, 0, 0, 2));
        ex(K_REQ, 32'b1001);
        ex_flags(4'b0, 4'b0, 4'b0, 1'b1);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000);
        ex(K_GERR, 32'b0);

        // Build counts 3/5/0/2, raise a flag, then asynchronous reset mid-cycle
        step(4'b0011, 4'b0000, 1'b0, 4'b0011);
        step(4'b0011, 4'b0000, 1'b0, 4'b0011);
        for (int i = 0; i < 3; i++) step(4'b0010, 4'b0000, 1'b0, 4'b0010);
        step(4'b0000, 4'b0100, 1'b0, 4'b0000);
        ex(K_PEND, pc(3, 5, 0, 2));
        ex(K_REQ, 32'b1011);
        ex(K_SPUR, 32'b0100);
        @(posedge clk);
        #2;
        reset = 1'b0;
        ex(K_PEND, 32'b0);
        ex(K_REQ, 32'b0);
        ex(K_ACK, 32'b0);
        ex_flags(4'b0, 4'b0, 4'b0, 1'b0);
        // Request during reset is not acked
        step(4'b0001, 4'b0000, 1'b0, 4'b0000);
        ex(K_PEND, 32'b0);
        reset = 1'b1;
        step(4'b0001, 4'b0000, 1'b0, 4'b0001);
        ex(K_PEND, pc(1, 0, 0, 0));
        ex(K_REQ, 32'b0001);

        repeat (3) @(posedge clk);
        #1;
        compare("ack_q_empty", cyc, 32'(ack_q.size()), 32'b0);
        compare("chk_q_empty", cyc, 32'(chk_q.size()), 32'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/req_agg.md
Name: req_agg

Overview:
- Request aggregator that sits directly upstream of the 4-way arbiter controller `ctrl`.
- Collects pulsed service requests from four sources and keeps a saturating pending count per source.
- Drives the level-sensitive `req_0`..`req_3` inputs of `ctrl` for as long as work is pending.
- Retires one pending request per grant pulse returned by `ctrl`, and flags overflow, spurious or multi-hot grants, and starvation timeouts.

Parameters:
- CNT_W, 3: width of each per-channel pending counter; max pending = 2^CNT_W-1.
- TMO_W, 8: width of each per-channel age counter.
- TMO_MAX, 200: cycles a channel may hold its request without a grant before timeout; must be < 2^TMO_W.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- src_req  in  4  one-cycle request pulse per source (bit i = source i).
- src_ack  out  4  registered; pulses high the cycle after src_req[i] is accepted.
- req_0  out  1  to ctrl; high while pending count of channel 0 is nonzero.
- req_1  out  1  same, channel 1.
- req_2  out  1  same, channel 2.
- req_3  out  1  same, channel 3.
- gnt  in  4  from ctrl; one-cycle grant pulse, expected one-hot, means one request of channel i serviced.
- clr_err  in  1  synchronous pulse; clears all sticky error flags.
- pend_cnt  out  4*CNT_W  pending counts; channel i occupies bits [i*CNT_W +: CNT_W].
- ovf  out  4  sticky; request dropped because the channel was full.
- tmo  out  4  sticky; channel age reached TMO_MAX.
- spur  out  4  sticky; gnt[i] arrived while channel i count was 0.
- gnt_err  out  1  sticky; more than one gnt bit set in the same cycle.

Behaviour:
- Reset (reset=0, async): all counters, age counters, src_ack, ovf, tmo, spur and gnt_err go to 0, so req_0..3 = 0 and pend_cnt = 0. Reset mid-operation discards all pending work; no ack is issued for a request in the reset cycle.
- Per channel i, evaluated each rising clk edge. Let full = (cnt == 2^CNT_W-1), inc = src_req[i] & (~full | gnt[i]), dec = gnt[i] & (cnt != 0).
  - inc & ~dec: cnt+1.
  - dec & ~inc: cnt-1.
  - both or neither: cnt unchanged.
  - Count never wraps.
- src_ack[i] <= inc. Latency is 1 cycle from src_req to src_ack.
- Full with simultaneous src_req and gnt: the request is accepted (net count unchanged, ack issued, no ovf).
- Full with src_req and no gnt: request dropped, src_ack[i]=0, ovf[i] <= 1.
- gnt[i] with cnt==0: ignored (count stays 0), spur[i] <= 1. If src_req[i] arrives the same cycle, cnt becomes 1.
- req_i is decoded from the registered count: req_i = (cnt != 0).
  - Latency: src_req at edge N gives req_i high after edge N.
  - The grant retiring the last request drops req_i after that same edge.
- Age counter per channel:
  - Cleared when req_i=0 or gnt[i]=1.
  - Otherwise increments each cycle, saturating at TMO_MAX.
  - On the edge where age becomes TMO_MAX, tmo[i] <= 1.
  - After a grant, age restarts from 0 if work is still pending.
- gnt_err <= 1 when popcount(gnt) > 1. Each granted channel is still decremented independently.
- clr_err clears ovf, tmo, spur and gnt_err. If an error condition occurs in the same cycle as clr_err, the set wins. Counters are unaffected.
- Error flags never affect request or grant flow.

Test Plan:
- Reset then src_req=4'b0001 for one cycle -> src_ack[0]=1 and req_0=1 one cycle later; pend_cnt ch0 = 1; gnt=4'b0001 one cycle -> req_0=0 next cycle, count 0.
- Pulse src_req[2] 8 times with no grants (CNT_W=3) -> 7 acks, count = 7, 8th pulse not acked, ovf[2]=1; a further src_req[2] together with gnt[2] -> acked, count stays 7, ovf unchanged.
- gnt=4'b1000 while channel 3 is idle -> spur[3]=1, count stays 0; clr_err pulse -> spur=0.
- Hold 1 pending on channel 1 with no grant -> tmo[1]=1 exactly 200 cycles after req_1 rises; gnt[1] -> age clears, tmo stays set until clr_err.
- Load channels 0 and 3, drive gnt=4'b1001 -> both counts decrement, gnt_err=1.
- Assert reset low asynchronously mid-clock with counts 3/5/0/2 -> all outputs 0 immediately, before the next clk edge.
